nx_fifo_rd_sched: RTL and testbench

//  Round-robin read scheduler that drains N_SRC nx_fifo instances into one valid/ready stream.

---
 rtl/nx_fifo_sched_pkg.sv | 4 +
 rtl/nx_rr_pick.sv | 24 ++
 rtl/nx_fifo_rd_sched.sv | 102 ++++++++++
 tb/tb_nx_fifo_rd_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_fifo_sched_pkg.sv
// nx_fifo_sched_pkg: shared types for the FIFO read scheduler
package nx_fifo_sched_pkg;
    typedef enum logic {IDLE, XFER} sched_state_e;
endpackage

// File: rtl/nx_rr_pick.sv
// nx_rr_pick: combinational round-robin picker, first set req after last (mod N)
module nx_rr_pick #(
    parameter int N     = 4,
    parameter int SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] last,
    output logic [SRC_W-1:0] pick,
    output logic             any
);
    logic [SRC_W-1:0] idx;

    // Scan farthest-first so the nearest candidate after last wins
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SRC_W'((int'(last) + k) % N);
            if (req[idx]) pick = idx;
        end
    end

    assign any = |req;
endmodule

// File: rtl/nx_fifo_rd_sched.sv
// nx_fifo_rd_sched: round-robin burst scheduler draining N_SRC show-ahead FIFOs
// into one valid/ready stream through a single output register.
module nx_fifo_rd_sched
    import nx_fifo_sched_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int WIDTH = 128,
    parameter int BURST = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC-1:0]       fifo_empty,
    input  logic [N_SRC*WIDTH-1:0] fifo_rdata,
    output logic [N_SRC-1:0]       fifo_ren,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRC_W-1:0]       out_src,
    output logic                   busy
);
    localparam int CNT_W = $clog2(BURST + 1);

    sched_state_e     state_q, state_d;
    logic [SRC_W-1:0] gnt_q, gnt_d, last_q, last_d, out_src_q, out_src_d, pick;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [N_SRC-1:0] req;
    logic             any, gnt_req, pop, done;

    assign req     = src_en & ~fifo_empty;
    assign gnt_req = req[gnt_q];
    assign pop     = (state_q == XFER) && gnt_req && (!out_valid_q || out_ready) && !clear;
    assign done    = (state_q == XFER) && ((pop && beat_cnt_q == CNT_W'(BURST - 1)) || !gnt_req);

    nx_rr_pick #(.N(N_SRC), .SRC_W(SRC_W)) u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_q      <= SRC_W'(N_SRC - 1);
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
        end else if (state_q == IDLE) begin
            if (any) begin
                state_d    = XFER;
                gnt_d      = pick;
                beat_cnt_d = '0;
            end
        end else begin
            if (pop) beat_cnt_d = beat_cnt_q + 1'b1;
            if (done) begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
        end
    end

    // A pop overwrites the register in the same cycle its old beat is consumed
    always_comb begin
        fifo_ren        = '0;
        fifo_ren[gnt_q] = pop;
        out_data_d      = pop ? fifo_rdata[gnt_q*WIDTH +: WIDTH] : out_data_q;
        out_src_d       = pop ? gnt_q : out_src_q;
        out_valid_d     = clear ? 1'b0 : (pop | (out_valid_q & ~out_ready));
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != IDLE) | out_valid_q;
endmodule

// File: tb/tb_nx_fifo_rd_sched.sv
// tb_nx_fifo_rd_sched: directed and random checks of the round-robin FIFO read scheduler
module tb_nx_fifo_rd_sched;
    localparam int N = 4, W = 32, B = 4, D = 64;

    logic           clk = 1'b0;
    logic           rst, clear, out_ready, flush;
    logic [N-1:0]   src_en, fifo_empty, fifo_ren;
    logic [N*W-1:0] fifo_rdata;
    logic           out_valid, busy;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;

    logic [W-1:0] mem [N][D];
    int wp [N] = '{default: 0};
    int rp [N] = '{default: 0};
    int ren_cnt [N] = '{default: 0};
    int checks = 0, errors = 0;
    logic [W-1:0] log_d [$];
    logic [1:0]   log_s [$];
    logic         pv, pr;
    logic [W-1:0] pd;
    logic [1:0]   ps;

    nx_fifo_rd_sched #(.N_SRC(N), .WIDTH(W), .BURST(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .src_en     (src_en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_fifo
        assign fifo_empty[g]          = wp[g] == rp[g];
        assign fifo_rdata[g*W +: W]   = mem[g][rp[g] % D];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (flush) rp[i] <= wp[i];
            else if (fifo_ren[i]) begin
                rp[i]      <= rp[i] + 1;
                ren_cnt[i] <= ren_cnt[i] + 1;
            end
        end
    end

    // Protocol monitor: no pop of empty FIFO, one-hot ren, stable held beat, beat log
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b1;
        end else begin
            if (fifo_ren != '0) begin
                checks++;
                if ((fifo_ren & fifo_empty) != '0 || (fifo_ren & (fifo_ren - 1'b1)) != '0) begin
                    errors++;
                    $display("FAIL ren_legal: ren=%b empty=%b", fifo_ren, fifo_empty);
                end
            end
            if (pv && !pr && out_valid) begin
                checks++;
                if (out_data !== pd || out_src !== ps) begin
                    errors++;
                    $display("FAIL hold_stable: got %h/%0d, expected %h/%0d", out_data, out_src, pd, ps);
                end
            end
            if (out_valid && out_ready) begin
                log_d.push_back(out_data);
                log_s.push_back(out_src);
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            ps = out_src;
        end
    end

    function automatic logic [W-1:0] beat(input int s, input int k);
        return W'((s << 16) | k);
    endfunction

    task automatic push(input int s, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            mem[s][wp[s] % D] = beat(s, base + k);
            wp[s]++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = out_valid;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_ren !== '0) begin errors++; $display("FAIL reset_ren: got %b expected 0", fifo_ren); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", out_src); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_burst;
        int t[$];
        int r0, fr;
        log_d.delete(); log_s.delete();
        r0 = ren_cnt[0];
        fr = -1;
        push(0, 6, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_ren[0] && fr < 0) fr = c;
            if (out_valid && out_ready) t.push_back(c);
        end
        checks++; if (fr != 1) begin errors++; $display("FAIL burst_ren_latency: got %0d expected 1", fr); end
        checks++; if (log_d.size() != 6 || t.size() != 6) begin
            errors++; $display("FAIL burst_count: got %0d expected 6", log_d.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (log_s[k] !== 2'd0 || log_d[k] !== beat(0, k)) begin
                    errors++; $display("FAIL burst_beat%0d: got %h/%0d expected %h/0", k, log_d[k], log_s[k], beat(0, k));
                end
            end
            checks++; if (t[0] != 2) begin errors++; $display("FAIL burst_out_latency: got %0d expected 2", t[0]); end
            checks++; if (t[3] - t[0] != 3) begin errors++; $display("FAIL burst_back_to_back: got %0d expected 3", t[3] - t[0]); end
            checks++; if (t[4] - t[3] != 2) begin errors++; $display("FAIL burst_bubble: got %0d expected 2", t[4] - t[3]); end
            checks++; if (t[5] - t[4] != 1) begin errors++; $display("FAIL burst_tail: got %0d expected 1", t[5] - t[4]); end
        end
        checks++; if (ren_cnt[0] - r0 != 6) begin errors++; $display("FAIL burst_ren_cycles: got %0d expected 6", ren_cnt[0] - r0); end
    endtask

    task automatic test_round_robin;
        int ord [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        log_d.delete(); log_s.delete();
        for (int s = 0; s < N; s++) push(s, 2, 0);
        cycles(40);
        checks++; if (log_d.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d expected 8", log_d.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (log_s[k] !== 2'(ord[k]) || log_d[k] !== beat(ord[k], k % 2)) begin
                    errors++; $display("FAIL rr_order%0d: got %h/%0d expected %h/%0d", k, log_d[k], log_s[k], beat(ord[k], k % 2), ord[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        log_d.delete(); log_s.delete();
        push(1, 3, 0);
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no valid expected valid"); end
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== beat(1, 1) || fifo_ren !== '0) begin
                errors++; $display("FAIL bp_stall%0d: got v=%b d=%h ren=%b expected v=1 d=%h ren=0", c, out_valid, out_data, fifo_ren, beat(1, 1));
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        cycles(10);
        checks++; if (log_d.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d expected 3", log_d.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (log_d[k] !== beat(1, k)) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", k, log_d[k], beat(1, k)); end
            end
        end
    endtask

    task automatic test_disable;
        bit ok;
        int r0;
        log_d.delete(); log_s.delete();
        r0 = ren_cnt[2];
        push(2, 3, 0);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = fifo_ren[2];
        end
        checks++; if (!ok) begin errors++; $display("FAIL dis_timeout: got no ren expected ren[2]"); end
        @(posedge clk);
        #1 src_en[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (fifo_ren[2] !== 1'b0) begin errors++; $display("FAIL dis_ren%0d: got 1 expected 0", c); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_idle: got busy=%b expected 0", busy); end
        checks++; if (log_d.size() != 1 || log_d[0] !== beat(2, 0)) begin
            errors++; $display("FAIL dis_delivered: got %0d beats expected 1 (%h)", log_d.size(), beat(2, 0));
        end
        @(posedge clk);
        #1 src_en[2] = 1'b1;
        cycles(15);
        checks++; if (log_d.size() != 3 || log_d[1] !== beat(2, 1) || log_d[2] !== beat(2, 2)) begin
            errors++; $display("FAIL dis_resume: got %0d beats expected 3", log_d.size());
        end
        checks++; if (ren_cnt[2] - r0 != 3) begin errors++; $display("FAIL dis_ren_total: got %0d expected 3", ren_cnt[2] - r0); end
    endtask

    task automatic test_clear;
        bit ok;
        push(3, 4, 0);
        wait_valid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_timeout: got no valid expected valid"); end
        @(posedge clk);
        #1;
        clear = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || fifo_ren !== '0) begin
            errors++; $display("FAIL clr_during: got v=%b ren=%b expected v=1 ren=0", out_valid, fifo_ren);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_ren !== '0) begin
            errors++; $display("FAIL clr_after: got v=%b busy=%b ren=%b expected 0 0 0", out_valid, busy, fifo_ren);
        end
        @(posedge clk);
        #1;
        log_d.delete(); log_s.delete();
        push(0, 1, 16);
        push(3, 1, 16);
        cycles(15);
        checks++; if (log_s.size() != 2 || log_s[0] !== 2'd3 || log_s[1] !== 2'd0) begin
            errors++; $display("FAIL clr_rr_order: got %0d beats first src %0d expected 2 beats 3 then 0", log_s.size(), log_s.size() > 0 ? log_s[0] : 2'd0);
        end
    endtask

    task automatic test_random;
        int sent [N] = '{default: 0};
        int seen [N] = '{default: 0};
        int bad [N] = '{default: 0};
        int total;
        log_d.delete(); log_s.delete();
        total = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            out_ready = $urandom_range(0, 3) != 0;
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(0, 3) == 0 && wp[s] - rp[s] < D - 4) begin
                    push(s, 1, 256 + sent[s]);
                    sent[s]++;
                    total++;
                end
            end
        end
        out_ready = 1'b1;
        cycles(300);
        checks++; if (log_d.size() != total) begin errors++; $display("FAIL rand_count: got %0d expected %0d", log_d.size(), total); end
        foreach (log_d[k]) begin
            if (log_d[k] !== beat(int'(log_s[k]), 256 + seen[log_s[k]])) bad[log_s[k]]++;
            seen[log_s[k]]++;
        end
        for (int s = 0; s < N; s++) begin
            checks++;
            if (bad[s] != 0 || seen[s] != sent[s]) begin
                errors++; $display("FAIL rand_order_src%0d: got %0d beats %0d misordered expected %0d in order", s, seen[s], bad[s], sent[s]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        src_en = '1;
        test_reset();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_disable();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
